// File: rtl/snitch_icache_event_ctr_pkg.sv
// Shared types for the icache event counters: the per-port event vector and
// the event index used to address one counter within a port.
package snitch_icache_event_ctr_pkg;

    localparam int unsigned NR_ICACHE_EVENTS = 4;

    typedef struct packed {
        logic l0_miss;
        logic l0_hit;
        logic l0_prefetch;
        logic l0_double_hit;
    } icache_events_t;

    // Values match the bit position of each field in icache_events_t.
    typedef enum logic [1:0] {
        EV_DOUBLE_HIT = 2'd0,
        EV_PREFETCH   = 2'd1,
        EV_HIT        = 2'd2,
        EV_MISS       = 2'd3
    } icache_event_idx_e;

endpackage

// File: rtl/snitch_icache_event_ctr_if.sv
// Read channel between a CSR/peripheral reader (master) and the event counter
// block (slave): request with optional read-and-clear, one-entry response.
interface snitch_icache_event_ctr_if #(
    parameter int unsigned NR_FETCH_PORTS = 4,
    parameter int unsigned CNT_WIDTH      = 32
);
    localparam int unsigned PW = (NR_FETCH_PORTS > 1) ? $clog2(NR_FETCH_PORTS) : 1;

    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [PW-1:0]        req_port_i;
    logic [1:0]           req_event_i;
    logic                 req_clear_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [CNT_WIDTH-1:0] rsp_data_o;
    logic                 rsp_ovf_o;

    modport master (
        output req_valid_i, req_port_i, req_event_i, req_clear_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_ovf_o
    );

    modport slave (
        input  req_valid_i, req_port_i, req_event_i, req_clear_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_ovf_o
    );

endinterface

// File: rtl/snitch_icache_event_ctr_cnt.sv
// One event counter with sticky overflow flag. SNITCH_ICACHE_CTR_SATURATE_EN
// makes the counter hold at all-ones instead of wrapping.
module snitch_icache_event_cnt #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 rd_clr_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 ovf_o
);

    logic all_ones;
    assign all_ones = &cnt_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_o <= '0;
            ovf_o <= 1'b0;
        end else if (rd_clr_i) begin
            // An event arriving in the clearing cycle starts the new count.
            cnt_o <= inc_i ? CNT_WIDTH'(1) : '0;
            ovf_o <= 1'b0;
        end else if (inc_i) begin
            if (all_ones) begin
`ifdef SNITCH_ICACHE_CTR_SATURATE_EN
                ovf_o <= 1'b1;
`else
                cnt_o <= '0;
                ovf_o <= 1'b1;
`endif
            end else begin
                cnt_o <= cnt_o + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/snitch_icache_event_ctr.sv
// Per-fetch-port icache event counters with a valid/ready read port.
// Define SNITCH_ICACHE_CTR_SATURATE_EN for saturating counters (default wraps).
module snitch_icache_event_ctr
    import snitch_icache_event_ctr_pkg::*;
#(
    parameter int unsigned NR_FETCH_PORTS = 4,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  icache_events_t [NR_FETCH_PORTS-1:0] events_i,
    input  logic                                enable_i,
    input  logic                                clear_i,
    snitch_icache_event_ctr_if.slave            bus
);

    localparam int unsigned PW = (NR_FETCH_PORTS > 1) ? $clog2(NR_FETCH_PORTS) : 1;

    logic [NR_FETCH_PORTS-1:0][NR_ICACHE_EVENTS-1:0] ev_bits;
    logic [CNT_WIDTH-1:0] cnt [NR_FETCH_PORTS][NR_ICACHE_EVENTS];
    logic                 ovf [NR_FETCH_PORTS][NR_ICACHE_EVENTS];

    logic                 accept;
    logic [CNT_WIDTH-1:0] sel_cnt;
    logic                 sel_ovf;
    logic                 rsp_valid_q;
    logic [CNT_WIDTH-1:0] rsp_data_q;
    logic                 rsp_ovf_q;

    assign ev_bits = events_i;

    assign bus.req_ready_o = !rsp_valid_q || bus.rsp_ready_i;
    assign accept          = bus.req_valid_i && bus.req_ready_o;

    for (genvar p = 0; p < NR_FETCH_PORTS; p++) begin : g_port
        for (genvar e = 0; e < NR_ICACHE_EVENTS; e++) begin : g_event
            logic inc;
            logic rd_clr;

            assign inc    = enable_i && ev_bits[p][e];
            assign rd_clr = accept && bus.req_clear_i
                         && (bus.req_port_i == PW'(p))
                         && (bus.req_event_i == 2'(e));

            snitch_icache_event_cnt #(
                .CNT_WIDTH (CNT_WIDTH)
            ) i_cnt (
                .clk_i    (clk_i),
                .rst_i    (rst_i),
                .clr_i    (clear_i),
                .rd_clr_i (rd_clr),
                .inc_i    (inc),
                .cnt_o    (cnt[p][e]),
                .ovf_o    (ovf[p][e])
            );
        end
    end

    // A port index with no matching counter falls through to zero.
    always_comb begin
        sel_cnt = '0;
        sel_ovf = 1'b0;
        for (int p = 0; p < NR_FETCH_PORTS; p++) begin
            if (bus.req_port_i == PW'(p)) begin
                sel_cnt = cnt[p][bus.req_event_i];
                sel_ovf = ovf[p][bus.req_event_i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= sel_cnt;
            rsp_ovf_q   <= sel_ovf;
        end else if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_ovf_o   = rsp_ovf_q;

endmodule
